// File: rtl/elapsed_time_meter_if.sv
// Control/result bundle between a measurement consumer (master) and the
// elapsed time meter (slave).
interface elapsed_time_meter_if #(
  parameter int unsigned SEC_W = 16
);
  logic             start;
  logic             stop;
  logic             ack;
  logic             busy;
  logic             valid;
  logic [SEC_W-1:0] elapsed_seconds;
  logic             overflow;

  modport master (
    output start, stop, ack,
    input  busy, valid, elapsed_seconds, overflow
  );

  modport slave (
    input  start, stop, ack,
    output busy, valid, elapsed_seconds, overflow
  );
endinterface

// File: rtl/elapsed_time_meter.sv
// Stopwatch: counts whole seconds between start and stop, holds the result
// until acknowledged, saturating at the top of the result range.
module elapsed_time_meter #(
  parameter int unsigned TICKS_PER_SECOND = 10000,
  parameter int unsigned SEC_W            = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  elapsed_time_meter_if.slave  bus
);

  localparam int unsigned PRE_W = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_clear;
  logic               w_wrap;
  logic               w_sec_max;
  logic [PRE_W-1:0]   r_pre;
  logic [SEC_W-1:0]   r_sec;
  logic               r_ovf;
  logic               r_busy;
  logic               r_valid;

  assign w_wrap    = (r_pre == PRE_W'(TICKS_PER_SECOND - 1));
  assign w_sec_max = &r_sec;

  // Next state; w_clear marks an accepted start (from IDLE or DONE).
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next  = S_RUN;
          w_clear = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.stop) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          w_next  = S_RUN;
          w_clear = 1'b1;
        end else if (bus.ack) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // busy/valid are flopped from the next state so they track r_state exactly.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_valid <= (w_next == S_DONE);
    end
  end

  // Prescaler and seconds counter; a wrap on the stop cycle still counts.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
      r_sec <= '0;
      r_ovf <= 1'b0;
    end else if (w_clear) begin
      r_pre <= '0;
      r_sec <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_wrap) begin
        r_pre <= '0;
        if (w_sec_max) r_ovf <= 1'b1;
        else           r_sec <= r_sec + SEC_W'(1);
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  assign bus.busy            = r_busy;
  assign bus.valid           = r_valid;
  assign bus.elapsed_seconds = r_sec;
  assign bus.overflow        = r_ovf;

endmodule

// File: tb/tb_elapsed_time_meter.sv
// Bench for elapsed_time_meter: two instances (10 ticks/16-bit, 2 ticks/4-bit)
// driven in lockstep, checked against an elapsed-cycle model and literals.
module tb_elapsed_time_meter;

  logic CLK;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  elapsed_time_meter_if #(.SEC_W(16)) ifa ();
  elapsed_time_meter_if #(.SEC_W(4))  ifb ();

  elapsed_time_meter #(.TICKS_PER_SECOND(10), .SEC_W(16)) dut_a (
    .CLK(CLK), .reset(reset), .bus(ifa.slave)
  );
  elapsed_time_meter #(.TICKS_PER_SECOND(2), .SEC_W(4)) dut_b (
    .CLK(CLK), .reset(reset), .bus(ifb.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int tk(input int k);
    return (k == 0) ? 10 : 2;
  endfunction

  function automatic int mx(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  // Model: seconds = cycles elapsed since the start edge / ticks, clamped.
  int m_el   [2] = '{0, 0};
  int m_sec  [2] = '{0, 0};
  bit m_ovf  [2] = '{0, 0};
  bit m_run  [2] = '{0, 0};
  bit m_done [2] = '{0, 0};

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_el[k] <= 0; m_sec[k] <= 0; m_ovf[k] <= 1'b0;
        m_run[k] <= 1'b0; m_done[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_run[k]) begin
          m_el[k]  <= m_el[k] + 1;
          m_sec[k] <= ((m_el[k] + 1) / tk(k) > mx(k)) ? mx(k) : (m_el[k] + 1) / tk(k);
          m_ovf[k] <= ((m_el[k] + 1) / tk(k) > mx(k));
          if (ifa.stop) begin
            m_run[k]  <= 1'b0;
            m_done[k] <= 1'b1;
          end
        end else if (ifa.start) begin
          m_run[k] <= 1'b1; m_done[k] <= 1'b0;
          m_el[k] <= 0; m_sec[k] <= 0; m_ovf[k] <= 1'b0;
        end else if (m_done[k] && ifa.ack) begin
          m_done[k] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    check("model A.busy",  int'(ifa.busy),            int'(m_run[0]));
    check("model A.valid", int'(ifa.valid),           int'(m_done[0]));
    check("model A.sec",   int'(ifa.elapsed_seconds), m_sec[0]);
    check("model A.ovf",   int'(ifa.overflow),        int'(m_ovf[0]));
    check("model B.busy",  int'(ifb.busy),            int'(m_run[1]));
    check("model B.valid", int'(ifb.valid),           int'(m_done[1]));
    check("model B.sec",   int'(ifb.elapsed_seconds), m_sec[1]);
    check("model B.ovf",   int'(ifb.overflow),        int'(m_ovf[1]));
  end

  // One sampled cycle with the given inputs, then inputs return low.
  task automatic step(input bit s, input bit p, input bit a);
    ifa.start = s; ifa.stop = p; ifa.ack = a;
    ifb.start = s; ifb.stop = p; ifb.ack = a;
    @(posedge CLK);
    #2;
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.ack = 1'b0;
    ifb.start = 1'b0; ifb.stop = 1'b0; ifb.ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    reset = 1'b1;
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.ack = 1'b0;
    ifb.start = 1'b0; ifb.stop = 1'b0; ifb.ack = 1'b0;
    #1 reset = 1'b0;
    idle(2);
    check("reset busy",  int'(ifa.busy), 0);
    check("reset valid", int'(ifa.valid), 0);
    check("reset sec",   int'(ifa.elapsed_seconds), 0);
    check("reset ovf",   int'(ifb.overflow), 0);
    reset = 1'b1;
    idle(1);

    // Basic measurement: start edge 0, stop edge 35
    step(1, 0, 0);
    check("start busy", int'(ifa.busy), 1);
    idle(9);
    check("edge9 sec", int'(ifa.elapsed_seconds), 0);
    idle(1);
    check("edge10 sec", int'(ifa.elapsed_seconds), 1);
    idle(24);
    step(0, 1, 0);
    check("basic valid", int'(ifa.valid), 1);
    check("basic busy",  int'(ifa.busy), 0);
    check("basic sec",   int'(ifa.elapsed_seconds), 3);
    check("basic ovf",   int'(ifa.overflow), 0);
    check("basic B sec", int'(ifb.elapsed_seconds), 15);
    check("basic B ovf", int'(ifb.overflow), 1);
    step(0, 0, 1);
    check("ack valid", int'(ifa.valid), 0);
    check("ack sec kept", int'(ifa.elapsed_seconds), 3);

    // Stop exactly on a wrap edge (30) is counted
    step(1, 0, 0);
    idle(29);
    step(0, 1, 0);
    check("wrap stop sec", int'(ifa.elapsed_seconds), 3);
    check("wrap B sec", int'(ifb.elapsed_seconds), 15);
    check("wrap B ovf", int'(ifb.overflow), 0);

    // Result held without ack
    idle(100);
    check("hold valid", int'(ifa.valid), 1);
    check("hold sec", int'(ifa.elapsed_seconds), 3);
    step(0, 0, 1);
    check("hold ack valid", int'(ifa.valid), 0);
    check("hold ack sec", int'(ifa.elapsed_seconds), 3);

    // Saturation of the 4-bit instance over 40 cycles
    step(1, 0, 0);
    idle(39);
    step(0, 1, 0);
    check("sat B sec", int'(ifb.elapsed_seconds), 15);
    check("sat B ovf", int'(ifb.overflow), 1);
    check("sat A sec", int'(ifa.elapsed_seconds), 4);
    step(0, 0, 1);
    check("sat idle ovf", int'(ifb.overflow), 1);
    check("sat idle sec", int'(ifb.elapsed_seconds), 15);

    // Simultaneous start+stop in IDLE, then in RUN, then start from DONE
    step(1, 1, 0);
    check("ss idle busy", int'(ifa.busy), 1);
    check("restart B ovf", int'(ifb.overflow), 0);
    check("restart B sec", int'(ifb.elapsed_seconds), 0);
    idle(11);
    step(1, 1, 0);
    check("ss run valid", int'(ifa.valid), 1);
    check("ss run sec", int'(ifa.elapsed_seconds), 1);
    step(1, 0, 0);
    check("done start busy", int'(ifa.busy), 1);
    check("done start valid", int'(ifa.valid), 0);
    check("done start sec", int'(ifa.elapsed_seconds), 0);

    // Asynchronous reset between edges mid-RUN
    idle(15);
    check("pre-reset sec", int'(ifa.elapsed_seconds), 1);
    #1 reset = 1'b0;
    #1;
    check("async busy", int'(ifa.busy), 0);
    check("async sec", int'(ifa.elapsed_seconds), 0);
    check("async B sec", int'(ifb.elapsed_seconds), 0);
    idle(1);
    reset = 1'b1;
    step(0, 1, 0);
    step(0, 0, 1);
    idle(5);
    check("post-reset valid", int'(ifa.valid), 0);
    check("post-reset busy", int'(ifa.busy), 0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
